// File: rtl/el2_pkg.sv
// Shared EL2 memory-subsystem types: arbitration modes and the per-bank read-tracking entry.
package el2_pkg;

  localparam int unsigned EL2_ARB_RR    = 0;
  localparam int unsigned EL2_ARB_FIXED = 1;

  // Wide enough for the largest supported channel count (8).
  localparam int unsigned EL2_ARB_CH_W = 3;

  typedef struct packed {
    logic                    vld;
    logic [EL2_ARB_CH_W-1:0] ch;
  } el2_mem_arb_trk_t;

endpackage

// File: rtl/el2_mem_rr_arb.sv
// One-hot grant from a request vector, round-robin from a pointer or fixed lowest-index priority.
module el2_mem_rr_arb
  import el2_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ARB_MODE = EL2_ARB_RR,
  localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    // Scan from the pointer (or from 0), wrapping once; the first requester found wins.
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = (ARB_MODE == EL2_ARB_FIXED) ? i : int'(ptr) + i;
      if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (c == idx && !found && req[c]) begin
          gnt[c] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/el2_mem_bank_arb.sv
// Per-bank arbiter driving shared SRAM strobes, with a fixed-latency read-return router.
module el2_mem_bank_arb
  import el2_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ECC_W     = 7,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ARB_MODE  = EL2_ARB_RR,
  localparam int unsigned BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                req_valid,
  output logic [NUM_CH-1:0]                req_ready,
  input  logic [NUM_CH-1:0]                req_we,
  input  logic [NUM_CH-1:0][BW-1:0]        req_bank,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NUM_CH-1:0][ECC_W-1:0]     req_wecc,
  output logic [NUM_CH-1:0]                rsp_valid,
  output logic [NUM_CH-1:0][DATA_W-1:0]    rsp_rdata,
  output logic [NUM_CH-1:0][ECC_W-1:0]     rsp_recc,
  output logic [NUM_BANKS-1:0]             bank_clken,
  output logic [NUM_BANKS-1:0]             bank_wren,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS-1:0][DATA_W-1:0] bank_wr_data,
  output logic [NUM_BANKS-1:0][ECC_W-1:0]  bank_wr_ecc,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_dout,
  input  logic [NUM_BANKS-1:0][ECC_W-1:0]  bank_ecc
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_BANKS-1:0][NUM_CH-1:0] cand;
  logic [NUM_BANKS-1:0][NUM_CH-1:0] gnt;
  logic [NUM_BANKS-1:0][CW-1:0]     rr_q, rr_d;

  el2_mem_arb_trk_t trk_q   [RD_LAT][NUM_BANKS];
  el2_mem_arb_trk_t trk_new [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cand
      // Reset masks every candidate so nothing is granted while rst is high.
      assign cand[b][c] = ~rst & req_valid[c] & (req_bank[c] == BW'(b));
    end

    el2_mem_rr_arb #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
    ) u_arb (
      .req (cand[b]),
      .ptr (rr_q[b]),
      .gnt (gnt[b])
    );
  end

  always_comb begin
    rr_d         = rr_q;
    req_ready    = '0;
    bank_clken   = '0;
    bank_wren    = '0;
    bank_addr    = '0;
    bank_wr_data = '0;
    bank_wr_ecc  = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      trk_new[b] = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (gnt[b][c]) begin
          req_ready[c]    = 1'b1;
          rr_d[b]         = (c == int'(NUM_CH) - 1) ? '0 : CW'(c + 1);
          bank_clken[b]   = 1'b1;
          bank_wren[b]    = req_we[c];
          bank_addr[b]    = req_addr[c];
          bank_wr_data[b] = req_wdata[c];
          bank_wr_ecc[b]  = req_wecc[c];
          trk_new[b].vld  = ~req_we[c];
          trk_new[b].ch   = EL2_ARB_CH_W'(c);
        end
      end
    end
  end

  // Final tracking stage lines up with the SRAM read data for that bank.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_recc  = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (trk_q[RD_LAT-1][b].vld && trk_q[RD_LAT-1][b].ch == EL2_ARB_CH_W'(c)) begin
          rsp_valid[c] = 1'b1;
          rsp_rdata[c] = bank_dout[b];
          rsp_recc[c]  = bank_ecc[b];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      for (int s = 0; s < int'(RD_LAT); s++) begin
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
          trk_q[s][b] <= '0;
        end
      end
    end else begin
      rr_q <= rr_d;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        trk_q[0][b] <= trk_new[b];
        for (int s = 1; s < int'(RD_LAT); s++) begin
          trk_q[s][b] <= trk_q[s-1][b];
        end
      end
    end
  end

endmodule

// File: tb/tb_el2_mem_bank_arb.sv
// Directed bench: three configurations share one stimulus; each sequence checks the relevant one.
module tb_el2_mem_bank_arb;

  logic                 clk;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [1:0][1:0]      req_bank;
  logic [1:0][11:0]     req_addr;
  logic [1:0][31:0]     req_wdata;
  logic [1:0][6:0]      req_wecc;
  logic [3:0][31:0]     bank_dout;
  logic [3:0][6:0]      bank_ecc;

  logic [1:0]       r2_ready, r2_rsp, r3_ready, r3_rsp, fx_ready, fx_rsp;
  logic [1:0][31:0] r2_rdata, r3_rdata, fx_rdata;
  logic [1:0][6:0]  r2_recc, r3_recc, fx_recc;
  logic [3:0]       r2_clken, r2_wren, r3_clken, r3_wren, fx_clken, fx_wren;
  logic [3:0][11:0] r2_addr, r3_addr, fx_addr;
  logic [3:0][31:0] r2_wdata, r3_wdata, fx_wdata;
  logic [3:0][6:0]  r2_wecc, r3_wecc, fx_wecc;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  el2_mem_bank_arb #(.NUM_CH(2), .NUM_BANKS(4), .ADDR_W(12), .DATA_W(32), .ECC_W(7),
                     .RD_LAT(2), .ARB_MODE(0)) u_r2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata), .req_wecc(req_wecc),
    .rsp_valid(r2_rsp), .rsp_rdata(r2_rdata), .rsp_recc(r2_recc), .bank_clken(r2_clken),
    .bank_wren(r2_wren), .bank_addr(r2_addr), .bank_wr_data(r2_wdata), .bank_wr_ecc(r2_wecc),
    .bank_dout(bank_dout), .bank_ecc(bank_ecc)
  );

  el2_mem_bank_arb #(.NUM_CH(2), .NUM_BANKS(4), .ADDR_W(12), .DATA_W(32), .ECC_W(7),
                     .RD_LAT(3), .ARB_MODE(0)) u_r3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r3_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata), .req_wecc(req_wecc),
    .rsp_valid(r3_rsp), .rsp_rdata(r3_rdata), .rsp_recc(r3_recc), .bank_clken(r3_clken),
    .bank_wren(r3_wren), .bank_addr(r3_addr), .bank_wr_data(r3_wdata), .bank_wr_ecc(r3_wecc),
    .bank_dout(bank_dout), .bank_ecc(bank_ecc)
  );

  el2_mem_bank_arb #(.NUM_CH(2), .NUM_BANKS(4), .ADDR_W(12), .DATA_W(32), .ECC_W(7),
                     .RD_LAT(1), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fx_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata), .req_wecc(req_wecc),
    .rsp_valid(fx_rsp), .rsp_rdata(fx_rdata), .rsp_recc(fx_recc), .bank_clken(fx_clken),
    .bank_wren(fx_wren), .bank_addr(fx_addr), .bank_wr_data(fx_wdata), .bank_wr_ecc(fx_wecc),
    .bank_dout(bank_dout), .bank_ecc(bank_ecc)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [1:0]  bank0;
    logic [1:0]  bank1;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata1;
    logic [6:0]  wecc1;
    logic [1:0]  ready;
    logic [3:0]  clken;
    logic [3:0]  wren;
    logic [1:0]  rsp;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [6:0]  recc0;
    logic [6:0]  recc1;
    logic        pchk;
    logic [1:0]  pbank;
    logic [11:0] paddr;
    logic [31:0] pdata;
    logic [6:0]  pecc;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] we, input logic [1:0] b0,
                       input logic [1:0] b1);
    req_valid   = valid;
    req_we      = we;
    req_bank[0] = b0;
    req_bank[1] = b1;
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_wecc  = '0;
    drive(2'b11, 2'b00, 2'd0, 2'd0);
    bank_dout[0] = 32'hA0A0_A0A0; bank_ecc[0] = 7'h10;
    bank_dout[1] = 32'hB1B1_B1B1; bank_ecc[1] = 7'h11;
    bank_dout[2] = 32'hDEAD_BEEF; bank_ecc[2] = 7'h2A;
    bank_dout[3] = 32'hC3C3_C3C3; bank_ecc[3] = 7'h13;

    for (int i = 0; i < NV; i++) v[i] = '{default: '0};
    // Single read: ch0 -> bank 2 addr 5, response two cycles later
    v[1].valid = 2'b01; v[1].bank0 = 2'd2; v[1].addr0 = 12'h005;
    v[1].ready = 2'b01; v[1].clken = 4'b0100;
    v[1].pchk = 1'b1; v[1].pbank = 2'd2; v[1].paddr = 12'h005;
    v[2].pchk = 1'b1; v[2].pbank = 2'd2;
    v[3].rsp = 2'b01; v[3].rdata0 = 32'hDEAD_BEEF; v[3].recc0 = 7'h2A;
    // Write: ch1 -> bank 0, never produces a response
    v[5].valid = 2'b10; v[5].we = 2'b10; v[5].bank1 = 2'd0; v[5].addr1 = 12'h010;
    v[5].wdata1 = 32'h1234_5678; v[5].wecc1 = 7'h11;
    v[5].ready = 2'b10; v[5].clken = 4'b0001; v[5].wren = 4'b0001;
    v[5].pchk = 1'b1; v[5].pbank = 2'd0; v[5].paddr = 12'h010;
    v[5].pdata = 32'h1234_5678; v[5].pecc = 7'h11;
    // Round-robin contention on bank 1
    for (int i = 9; i <= 12; i++) begin
      v[i].valid = 2'b11; v[i].bank0 = 2'd1; v[i].bank1 = 2'd1; v[i].clken = 4'b0010;
      v[i].ready = (i % 2 == 1) ? 2'b01 : 2'b10;
    end
    v[11].rsp = 2'b01; v[11].rdata0 = 32'hB1B1_B1B1; v[11].recc0 = 7'h11;
    v[12].rsp = 2'b10; v[12].rdata1 = 32'hB1B1_B1B1; v[12].recc1 = 7'h11;
    // Parallel banks 0 and 3
    v[13].valid = 2'b11; v[13].bank0 = 2'd0; v[13].bank1 = 2'd3;
    v[13].ready = 2'b11; v[13].clken = 4'b1001;
    v[13].rsp = 2'b01; v[13].rdata0 = 32'hB1B1_B1B1; v[13].recc0 = 7'h11;
    v[14].rsp = 2'b10; v[14].rdata1 = 32'hB1B1_B1B1; v[14].recc1 = 7'h11;
    v[15].rsp = 2'b11; v[15].rdata0 = 32'hA0A0_A0A0; v[15].recc0 = 7'h10;
    v[15].rdata1 = 32'hC3C3_C3C3; v[15].recc1 = 7'h13;

    // Reset state with requests pending
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_r2", {30'd0, r2_ready}, 32'd0);
    chk("rst_ready_fx", {30'd0, fx_ready}, 32'd0);
    chk("rst_clken_r2", {28'd0, r2_clken}, 32'd0);
    chk("rst_wren_r2", {28'd0, r2_wren}, 32'd0);
    chk("rst_rsp_r3", {30'd0, r3_rsp}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(v[i].valid, v[i].we, v[i].bank0, v[i].bank1);
      req_addr[0]  = v[i].addr0;
      req_addr[1]  = v[i].addr1;
      req_wdata[1] = v[i].wdata1;
      req_wecc[1]  = v[i].wecc1;
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, r2_ready}, {30'd0, v[i].ready});
      chk($sformatf("v%0d_clken", i), {28'd0, r2_clken}, {28'd0, v[i].clken});
      chk($sformatf("v%0d_wren", i), {28'd0, r2_wren}, {28'd0, v[i].wren});
      chk($sformatf("v%0d_rsp", i), {30'd0, r2_rsp}, {30'd0, v[i].rsp});
      if (v[i].rsp[0]) begin
        chk($sformatf("v%0d_rdata0", i), r2_rdata[0], v[i].rdata0);
        chk($sformatf("v%0d_recc0", i), {25'd0, r2_recc[0]}, {25'd0, v[i].recc0});
      end
      if (v[i].rsp[1]) begin
        chk($sformatf("v%0d_rdata1", i), r2_rdata[1], v[i].rdata1);
        chk($sformatf("v%0d_recc1", i), {25'd0, r2_recc[1]}, {25'd0, v[i].recc1});
      end
      if (v[i].pchk) begin
        chk($sformatf("v%0d_addr", i), {20'd0, r2_addr[v[i].pbank]}, {20'd0, v[i].paddr});
        chk($sformatf("v%0d_wdata", i), r2_wdata[v[i].pbank], v[i].pdata);
        chk($sformatf("v%0d_wecc", i), {25'd0, r2_wecc[v[i].pbank]}, {25'd0, v[i].pecc});
      end
    end
    req_addr  = '0;
    req_wdata = '0;
    req_wecc  = '0;

    // Fixed priority: ch1 starves for 8 cycles, ch0 reads return one cycle later
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 2'd0, 2'd0);
      #1;
      chk($sformatf("fx%0d_ready", k), {30'd0, fx_ready}, 32'd1);
      if (k > 0) begin
        chk($sformatf("fx%0d_rsp", k), {30'd0, fx_rsp}, 32'd1);
        chk($sformatf("fx%0d_rdata", k), fx_rdata[0], 32'hA0A0_A0A0);
      end
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0);
    #1;
    chk("fx_last_rsp", {30'd0, fx_rsp}, 32'd1);

    // Reset mid-flight on the RD_LAT=3 instance; rr[0] is 1 here, so reset must restore 0
    @(negedge clk);
    drive(2'b01, 2'b00, 2'd0, 2'd0);
    #1;
    chk("mr_issue_ready", {30'd0, r3_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'd0, 2'd0);
    #1;
    chk("mr_rst_ready", {30'd0, r3_ready}, 32'd0);
    chk("mr_rst_clken", {28'd0, r3_clken}, 32'd0);
    chk("mr_rst_rsp", {30'd0, r3_rsp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_first_ready", {30'd0, r3_ready}, 32'd1);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0);
    #1;
    chk("mr_t3_rsp", {30'd0, r3_rsp}, 32'd0);
    @(negedge clk);
    #1;
    chk("mr_t4_rsp", {30'd0, r3_rsp}, 32'd0);
    @(negedge clk);
    #1;
    chk("mr_t5_rsp", {30'd0, r3_rsp}, 32'd1);
    chk("mr_t5_rdata", r3_rdata[0], 32'hA0A0_A0A0);
    @(negedge clk);
    #1;
    chk("mr_t6_rsp", {30'd0, r3_rsp}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
